// File: rtl/div_seq.sv
// Restoring DIV/DIVU sequencer for the EX-stage HI/LO path; result_o = {remainder, quotient}.
// Latency: ready_o in cycle DATA_W+2 after accept; cycle 2 for divide-by-zero or (DIV_EARLY_OUT_EN) |dividend| < |divisor|.
// Backpressure: stallreq_o holds EX while start_i is high and no result is ready; annul_i aborts to FREE at any time.
module div_seq #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);

    localparam int               CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  dividend;   // shifts dividend out at the MSB, quotient in at the LSB
    logic [DATA_W-1:0]  divisor;
    logic [DATA_W-1:0]  rem;        // partial remainder, always < divisor between steps
    logic               sign1, sign2, signed_q;

    logic [DATA_W-1:0]  mag1, mag2;
    logic               accept, div_zero, early_out;
    logic [DATA_W:0]    shifted;
    logic               ge;
    logic [DATA_W-1:0]  rem_sub, q_fix, r_fix;

    // Operand magnitudes: only negative operands of a signed divide are negated.
    // INT_MIN negates to itself, which is its correct unsigned magnitude.
    assign mag1     = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign mag2     = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    assign accept   = (state == FREE) && start_i && !annul_i;
    assign div_zero = (opdata2_i == '0);

`ifdef DIV_EARLY_OUT_EN
    assign early_out = !div_zero && (mag1 < mag2);
`else
    assign early_out = 1'b0;
`endif

    // One restoring step: the compare is DATA_W+1 wide; the difference always fits in DATA_W.
    assign shifted = {rem, dividend[DATA_W-1]};
    assign ge      = (shifted >= {1'b0, divisor});
    assign rem_sub = shifted[DATA_W-1:0] - divisor;

    // Sign correction: quotient negative when operand signs differ, remainder follows the dividend.
    assign q_fix = (signed_q && (sign1 ^ sign2)) ? -dividend : dividend;
    assign r_fix = (signed_q && sign1) ? -rem : rem;

    assign stallreq_o = start_i & ~ready_o & rst;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= FREE;
        else      state <= state_nxt;
    end

    // Next-state logic; annul_i wins over everything.
    always_comb begin
        state_nxt = state;
        case (state)
            FREE: begin
                if (start_i) begin
                    if (div_zero || early_out) state_nxt = BYZERO;
                    else                       state_nxt = ON;
                end
            end
            BYZERO:  state_nxt = END;
            ON:      if (cnt == CNT_LAST) state_nxt = END;
            END:     if (!start_i) state_nxt = FREE;
            default: state_nxt = FREE;
        endcase
        if (annul_i) state_nxt = FREE;
    end

    // Datapath: operand latch, iteration, result load and clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            signed_q <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    if (accept) begin
                        cnt      <= '0;
                        dividend <= mag1;
                        divisor  <= mag2;
                        // The short path reports the raw dividend as remainder; zero otherwise.
                        rem      <= early_out ? opdata1_i : '0;
                        sign1    <= opdata1_i[DATA_W-1];
                        sign2    <= opdata2_i[DATA_W-1];
                        signed_q <= signed_div_i;
                    end
                end
                BYZERO: begin
                    result_o <= {rem, {DATA_W{1'b0}}};
                    ready_o  <= 1'b1;
                end
                ON: begin
                    if (cnt != CNT_LAST) begin
                        rem      <= ge ? rem_sub : shifted[DATA_W-1:0];
                        dividend <= {dividend[DATA_W-2:0], ge};
                        cnt      <= cnt + CNT_W'(1);
                    end else begin
                        result_o <= {r_fix, q_fix};
                        ready_o  <= 1'b1;
                    end
                end
                END: begin
                    if (!start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (annul_i) begin
                cnt      <= '0;
                result_o <= '0;
                ready_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, results, stall, annul, reset and divide-by-zero.
// Latency is counted in cycles from the accepting cycle (cycle 0).
// Expected values are hand-computed constants.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic        start_i, annul_i;
    logic [63:0] result_o;
    logic        ready_o, stallreq_o;

    int n_tests = 0;
    int n_fail  = 0;

    div_seq #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    always #5 clk = ~clk;

`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_CYC = 2;
`else
    localparam int EARLY_CYC = 34;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Accept one divide, scramble operands afterwards, measure latency, then release.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int exp_cyc, input logic [63:0] exp_res);
        int cyc;
        int stall_bad;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        #1;
        stall_bad = (stallreq_o !== 1'b1) ? 1 : 0;
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                opdata1_i    = 32'hDEADBEEF;
                opdata2_i    = 32'h00000003;
                signed_div_i = ~sgn;
            end
            if (ready_o === 1'b1) break;
            if (stallreq_o !== 1'b1) stall_bad++;
        end
        check({tag, "_cycle"}, 64'(cyc), 64'(exp_cyc));
        check({tag, "_result"}, result_o, exp_res);
        check({tag, "_stall_busy"}, 64'(stall_bad), 64'd0);
        check({tag, "_stall_done"}, {63'd0, stallreq_o}, 64'd0);
        // Held while start_i stays high.
        @(posedge clk);
        #1;
        check({tag, "_hold"}, {ready_o, result_o[62:0]}, {1'b1, exp_res[62:0]});
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_release"}, {63'd0, ready_o} | result_o, 64'd0);
    endtask

    initial begin
        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", {61'd0, ready_o, stallreq_o, 1'b0} | result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle_out", {62'd0, ready_o, stallreq_o} | result_o, 64'd0);

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 34, {32'd2, 32'd14});
        run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 34, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 34, {32'h00000001, 32'hFFFFFFFD});
        run_div("div_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 34, {32'hFFFFFFFE, 32'hFFFFFFF2});
        run_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 34, {32'd0, 32'hFFFFFFFF});
        run_div("divu_max_m1", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, {32'd0, 32'd1});
        run_div("divu_by0", 1'b0, 32'h1234, 32'd0, 2, 64'd0);
        run_div("div_intmin_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 34, {32'h0, 32'h80000000});
        run_div("divu_5_9", 1'b0, 32'd5, 32'd9, EARLY_CYC, {32'd5, 32'd0});

        // Annul in cycle 10 of DIVU 50/3: no result may appear.
        begin
            int seen;
            @(negedge clk);
            signed_div_i = 1'b0;
            opdata1_i    = 32'd50;
            opdata2_i    = 32'd3;
            start_i      = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            annul_i = 1'b1;
            start_i = 1'b0;
            @(posedge clk);
            #1;
            annul_i = 1'b0;
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (ready_o !== 1'b0 || result_o !== 64'd0) seen++;
                @(posedge clk);
                #1;
            end
            check("annul_quiet", 64'(seen), 64'd0);
        end
        run_div("divu_50_3", 1'b0, 32'd50, 32'd3, 34, {32'd2, 32'd16});

        // Reset asserted in cycle 20 of a divide.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd50;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_out", {62'd0, ready_o, stallreq_o} | result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst     = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("midreset_idle", {63'd0, ready_o} | result_o, 64'd0);
        run_div("after_reset", 1'b0, 32'd100, 32'd7, 34, {32'd2, 32'd14});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
